// File: rtl/kbd_scan_tracker_pkg.sv
// Shared keyboard definitions: PS/2 set-2 scan-code constants
// and the decode FSM state encoding.
package kbd_scan_tracker_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } kbd_state_e;

endpackage

// File: rtl/kbd_scan_tracker_scan2ascii.sv
// Set-2 make code to unshifted ASCII; unmapped codes yield 0x00.
module scan2ascii (
    input  logic [7:0] code,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        case (code)
            8'h1C: ascii = 8'h61;
            8'h32: ascii = 8'h62;
            8'h21: ascii = 8'h63;
            8'h23: ascii = 8'h64;
            8'h24: ascii = 8'h65;
            8'h2B: ascii = 8'h66;
            8'h34: ascii = 8'h67;
            8'h33: ascii = 8'h68;
            8'h43: ascii = 8'h69;
            8'h3B: ascii = 8'h6A;
            8'h42: ascii = 8'h6B;
            8'h4B: ascii = 8'h6C;
            8'h3A: ascii = 8'h6D;
            8'h31: ascii = 8'h6E;
            8'h44: ascii = 8'h6F;
            8'h4D: ascii = 8'h70;
            8'h15: ascii = 8'h71;
            8'h2D: ascii = 8'h72;
            8'h1B: ascii = 8'h73;
            8'h2C: ascii = 8'h74;
            8'h3C: ascii = 8'h75;
            8'h2A: ascii = 8'h76;
            8'h1D: ascii = 8'h77;
            8'h22: ascii = 8'h78;
            8'h35: ascii = 8'h79;
            8'h1A: ascii = 8'h7A;
            8'h45: ascii = 8'h30;
            8'h16: ascii = 8'h31;
            8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;
            8'h25: ascii = 8'h34;
            8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;
            8'h3D: ascii = 8'h37;
            8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            8'h29: ascii = 8'h20;
            8'h5A: ascii = 8'h0D;
            default: ascii = 8'h00;
        endcase
    end

endmodule

// File: rtl/kbd_scan_tracker.sv
// PS/2 scan-code tracker: pops bytes from the receiver FIFO, decodes
// make/break/extended prefixes, tracks shift/caps and emits key pulses.
module kbd_scan_tracker
    import kbd_scan_tracker_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       data,
    input  logic             ready,
    output logic             nextdata_n,
    output logic [7:0]       raw_ascii,
    output logic             key_valid,
    output logic             shift,
    output logic             capslock,
    output logic [CNT_W-1:0] press_count
);

    kbd_state_e       state_q, state_d;
    logic             pop_q, pop_d;
    logic             hold_q, hold_d;
    logic [7:0]       raw_q, raw_d;
    logic             kv_q, kv_d;
    logic             lsh_q, lsh_d;
    logic             rsh_q, rsh_d;
    logic             caps_q, caps_d;
    logic             caps_held_q, caps_held_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       lut_ascii;
    logic             capture;

    scan2ascii u_scan2ascii (
        .code  (data),
        .ascii (lut_ascii)
    );

    // Pop strobe and its trailing hold cycle form the guard.
    assign capture = ready && !pop_q && !hold_q;

    always_comb begin
        state_d     = state_q;
        pop_d       = 1'b0;
        hold_d      = pop_q;
        raw_d       = raw_q;
        kv_d        = 1'b0;
        lsh_d       = lsh_q;
        rsh_d       = rsh_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, kv_q};
        if (capture) begin
            pop_d = 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    if (data == SC_BREAK) begin
                        state_d = ST_BRK;
                    end else if (data == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (data == SC_LSHIFT) begin
                        lsh_d = 1'b1;
                    end else if (data == SC_RSHIFT) begin
                        rsh_d = 1'b1;
                    end else if (data == SC_CAPS) begin
                        // Only the first make of a hold toggles.
                        caps_d      = caps_q ^ ~caps_held_q;
                        caps_held_d = 1'b1;
                    end else if (lut_ascii != 8'h00) begin
                        raw_d = lut_ascii;
                        kv_d  = 1'b1;
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                    if (data == SC_LSHIFT) lsh_d = 1'b0;
                    if (data == SC_RSHIFT) rsh_d = 1'b0;
                    if (data == SC_CAPS) caps_held_d = 1'b0;
                end
                ST_EXT: begin
                    state_d = (data == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                end
                ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= ST_IDLE;
            pop_q       <= 1'b0;
            hold_q      <= 1'b0;
            raw_q       <= 8'h00;
            kv_q        <= 1'b0;
            lsh_q       <= 1'b0;
            rsh_q       <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pop_q       <= pop_d;
            hold_q      <= hold_d;
            raw_q       <= raw_d;
            kv_q        <= kv_d;
            lsh_q       <= lsh_d;
            rsh_q       <= rsh_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            cnt_q       <= cnt_d;
        end
    end

    assign nextdata_n  = ~pop_q;
    assign raw_ascii   = raw_q;
    assign key_valid   = kv_q;
    assign shift       = lsh_q | rsh_q;
    assign capslock    = caps_q;
    assign press_count = cnt_q;

endmodule

// File: tb/tb_kbd_scan_tracker.sv
// Self-checking bench for kbd_scan_tracker: directed sequences plus
// random scan-code streams against a behavioural keyboard model.
module tb_kbd_scan_tracker;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready = 1'b0;
    logic       nextdata_n;
    logic [7:0] raw_ascii;
    logic       key_valid;
    logic       shift;
    logic       capslock;
    logic [7:0] press_count;

    int checks = 0;
    int errors = 0;

    // Reference keyboard state
    bit       m_brk, m_ext, m_extbrk;
    bit       m_lsh, m_rsh, m_caps, m_caps_down;
    bit [7:0] m_raw, m_cnt;

    kbd_scan_tracker #(.CNT_W(8)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .data        (data),
        .ready       (ready),
        .nextdata_n  (nextdata_n),
        .raw_ascii   (raw_ascii),
        .key_valid   (key_valid),
        .shift       (shift),
        .capslock    (capslock),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit [7:0] ref_ascii(input bit [7:0] sc);
        bit [7:0] r;
        case (sc)
            8'h1C: r = "a";
            8'h32: r = "b";
            8'h21: r = "c";
            8'h16: r = "1";
            8'h29: r = " ";
            8'h5A: r = 8'h0D;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_brk = 0; m_ext = 0; m_extbrk = 0;
        m_lsh = 0; m_rsh = 0; m_caps = 0; m_caps_down = 0;
        m_raw = 8'h00; m_cnt = 8'h00;
    endtask

    task automatic model_byte(input bit [7:0] b, output bit kv);
        bit [7:0] a;
        kv = 0;
        if (m_extbrk) begin
            m_extbrk = 0;
        end else if (m_ext) begin
            m_ext = 0;
            m_extbrk = (b == 8'hF0);
        end else if (m_brk) begin
            m_brk = 0;
            if (b == 8'h12) m_lsh = 0;
            if (b == 8'h59) m_rsh = 0;
            if (b == 8'h58) m_caps_down = 0;
        end else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'h12) m_lsh = 1;
        else if (b == 8'h59) m_rsh = 1;
        else if (b == 8'h58) begin
            if (!m_caps_down) m_caps = !m_caps;
            m_caps_down = 1;
        end else begin
            a = ref_ascii(b);
            if (a != 0) begin
                m_raw = a;
                kv = 1;
                m_cnt = m_cnt + 8'd1;
            end
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        ready = 0;
        clrn = 0;
        #1;
        chk("rst_nextdata_n", nextdata_n, 1);
        chk("rst_raw", raw_ascii, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_shift", shift, 0);
        chk("rst_caps", capslock, 0);
        chk("rst_count", press_count, 0);
        #2;
        clrn = 1;
        model_reset();
    endtask

    task automatic send(input logic [7:0] b);
        bit got;
        bit kv;
        got = 0;
        @(negedge clk);
        data = b;
        ready = 1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk);
            #1;
            if (nextdata_n === 1'b0) got = 1;
        end
        ready = 0;
        chk("pop_seen", got, 1);
        if (got) begin
            model_byte(b, kv);
            chk("key_valid", key_valid, kv);
            chk("raw_ascii", raw_ascii, m_raw);
            chk("shift", shift, m_lsh | m_rsh);
            chk("capslock", capslock, m_caps);
            @(posedge clk);
            #1;
            chk("key_valid_end", key_valid, 0);
            chk("nextdata_n_end", nextdata_n, 1);
            chk("press_count", press_count, m_cnt);
        end
    endtask

    initial begin
        logic [7:0] pool [14];
        int pops;
        int last;
        bit kv;

        pool = '{8'hF0, 8'hE0, 8'h12, 8'h59, 8'h58, 8'h1C, 8'h32,
                 8'h21, 8'h16, 8'h29, 8'h5A, 8'h05, 8'h76, 8'h75};
        model_reset();
        reset_pulse();

        // Single tap of 'a'
        send(8'h1C); send(8'hF0); send(8'h1C);
        chk("tap_raw", raw_ascii, 8'h61);
        chk("tap_count", press_count, 1);

        // Shifted '1'
        send(8'h12); send(8'h16);
        chk("shift_during", shift, 1);
        send(8'hF0); send(8'h16); send(8'hF0); send(8'h12);
        chk("shift_raw", raw_ascii, 8'h31);
        chk("shift_after", shift, 0);

        // Caps lock with auto-repeat
        send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
        chk("caps_on", capslock, 1);
        send(8'h58); send(8'hF0); send(8'h58);
        chk("caps_off", capslock, 0);

        // Extended keys change nothing
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h12);
        chk("ext_shift", shift, 0);
        chk("ext_raw", raw_ascii, 8'h31);

        // Continuous ready: one pop every 3 cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        data = 8'h05;
        ready = 1;
        pops = 0;
        last = -1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (nextdata_n === 1'b0) begin
                if (last >= 0) chk("pop_gap", c - last, 3);
                last = c;
                pops++;
                model_byte(8'h05, kv);
                chk("cont_key_valid", key_valid, kv);
            end
        end
        ready = 0;
        chk("cont_pops_ge4", pops >= 4, 1);
        @(posedge clk);

        // Random streams
        for (int n = 0; n < 400; n++) begin
            send(pool[$urandom_range(13, 0)]);
        end

        // Counter wrap
        reset_pulse();
        for (int n = 0; n < 255; n++) send(8'h1C);
        chk("count_ff", press_count, 8'hFF);
        send(8'h1C);
        chk("count_wrap", press_count, 8'h00);

        // Reset discards a pending break prefix
        send(8'hF0);
        reset_pulse();
        send(8'h1C);
        chk("rst_mid_raw", raw_ascii, 8'h61);
        chk("rst_mid_count", press_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
